// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath sequencer.
// Covers opcodes, instruction field positions, FSM states and opcode classification.
package datapath_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RA_MSB  = 27;
  localparam int RA_LSB  = 24;
  localparam int RB_MSB  = 23;
  localparam int RB_LSB  = 20;
  localparam int RC_MSB  = 19;
  localparam int RC_LSB  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_Y  = 3'd1,
    S_OPER    = 3'd2,
    S_WB_LO   = 3'd3,
    S_WB_HI   = 3'd4,
    S_DONE    = 3'd5,
    S_ILLEGAL = 3'd6
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b0;
      default:                                        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction splitter: pulls out opcode and register fields
// and classifies the opcode so the FSM can pick its first state.
module seq_decode
  import datapath_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  opc_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  rc_o,
  output logic        muldiv_o,
  output logic        unary_o,
  output logic        reserved_o
);

  assign opc_o      = instr_i[OPC_MSB:OPC_LSB];
  assign ra_o       = instr_i[RA_MSB:RA_LSB];
  assign rb_o       = instr_i[RB_MSB:RB_LSB];
  assign rc_o       = instr_i[RC_MSB:RC_LSB];
  assign muldiv_o   = is_muldiv(opc_o);
  assign unary_o    = is_unary(opc_o);
  assign reserved_o = is_reserved(opc_o);

  // The low half-word carries nothing for register-register ops.
  logic unused_low;
  assign unused_low = ^instr_i[15:0];

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the single-bus register datapath: takes one ALU
// instruction per valid/ready handshake and sequences the datapath strobes.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter int OPC_W         = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [NUM_REGS-1:0] R_in,
  output logic [NUM_REGS-1:0] R_out,
  output logic                RYIn,
  output logic                RZHiIn,
  output logic                RZLoIn,
  output logic                RZHiOut,
  output logic                RZLoOut,
  output logic                RHiIn,
  output logic                RLoIn,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [2:0]          dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_ready is 1 only in IDLE, and instr must be held until then.

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [3:0]       opc_q, opc_d;
  logic [3:0]       ra_q, ra_d;
  logic [3:0]       rb_q, rb_d;
  logic [3:0]       rc_q, rc_d;
  logic             muldiv_q, muldiv_d;
  logic             unary_q, unary_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_opc, dec_ra, dec_rb, dec_rc;
  logic       dec_muldiv, dec_unary, dec_reserved;

  seq_decode u_decode (
    .instr_i    (instr),
    .opc_o      (dec_opc),
    .ra_o       (dec_ra),
    .rb_o       (dec_rb),
    .rc_o       (dec_rc),
    .muldiv_o   (dec_muldiv),
    .unary_o    (dec_unary),
    .reserved_o (dec_reserved)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      muldiv_q <= 1'b0;
      unary_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      muldiv_q <= muldiv_d;
      unary_q  <= unary_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    muldiv_d = muldiv_q;
    unary_d  = unary_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          opc_d    = dec_opc;
          ra_d     = dec_ra;
          rb_d     = dec_rb;
          rc_d     = dec_rc;
          muldiv_d = dec_muldiv;
          unary_d  = dec_unary;
          if (dec_reserved) begin
            state_d = S_ILLEGAL;
          end else if (dec_unary) begin
            state_d = S_OPER;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD_Y;
          end
        end
      end
      S_LOAD_Y: begin
        state_d = S_OPER;
        cnt_d   = muldiv_q ? CNT_W'(MULDIV_CYCLES - 1) : '0;
      end
      S_OPER: begin
        if (cnt_q == '0) state_d = S_WB_LO;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WB_LO:   state_d = muldiv_q ? S_WB_HI : S_DONE;
      S_WB_HI:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ILLEGAL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are a pure decode of the registered state and latched fields.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    opcode      = (state_q == S_IDLE) ? '0 : OPC_W'(opc_q);
    R_in        = '0;
    R_out       = '0;
    RYIn        = 1'b0;
    RZHiIn      = 1'b0;
    RZLoIn      = 1'b0;
    RZHiOut     = 1'b0;
    RZLoOut     = 1'b0;
    RHiIn       = 1'b0;
    RLoIn       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_LOAD_Y: begin
        R_out = NUM_REGS'(1) << rb_q;
        RYIn  = 1'b1;
      end
      S_OPER: begin
        R_out  = NUM_REGS'(1) << (unary_q ? rb_q : rc_q);
        RZHiIn = 1'b1;
        RZLoIn = 1'b1;
      end
      S_WB_LO: begin
        RZLoOut = 1'b1;
        if (muldiv_q) RLoIn = 1'b1;
        else          R_in  = NUM_REGS'(1) << ra_q;
      end
      S_WB_HI: begin
        RZHiOut = 1'b1;
        RHiIn   = 1'b1;
      end
      S_DONE:    done    = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule
